// File: rtl/program_loader.sv
// Serial program loader: receives 8N1 UART bytes while programming mode is requested and writes
// each one as an instruction word into consecutive program-memory addresses, holding the core.
module program_loader #(
    parameter int unsigned CLKS_PER_BIT         = 1042,
    parameter int unsigned OPERATION_CODE_WIDTH = 3,
    parameter int unsigned REGISTER_WIDTH       = 4,
    parameter int unsigned MEMORY_ADDRESS_WIDTH = 4,
    parameter int unsigned MEMORY_REGISTERS     = 16
) (
    input  logic                                         clk_i,
    input  logic                                         reset_i,
    input  logic                                         p_programm_i,
    input  logic                                         rx_i,
    output logic                                         mem_we_o,
    output logic [MEMORY_ADDRESS_WIDTH-1:0]              mem_addr_o,
    output logic [OPERATION_CODE_WIDTH+REGISTER_WIDTH-1:0] mem_data_o,
    output logic                                         cpu_hold_o,
    output logic                                         done_o,
    output logic                                         error_o
);
    localparam int unsigned WORD_W = OPERATION_CODE_WIDTH + REGISTER_WIDTH;
    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW     = MEMORY_ADDRESS_WIDTH;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW-1:0]    ADDR_LAST = AW'(MEMORY_REGISTERS - 1);

    typedef enum logic [2:0] {
        StIdle, StWaitStart, StStart, StData, StStop, StWrite, StDone, StAbort
    } state_e;

    state_e              state_q, state_d;
    logic                prog_meta_q, prog_s, prog_prev_q;
    logic                rx_meta_q, rx_s;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic                we_q, we_d;
    logic [AW-1:0]       maddr_q, maddr_d;
    logic [WORD_W-1:0]   mdata_q, mdata_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                receiving;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prog_meta_q <= 1'b0;
            prog_s      <= 1'b0;
            prog_prev_q <= 1'b0;
            rx_meta_q   <= 1'b1;
            rx_s        <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            maddr_q     <= '0;
            mdata_q     <= '0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            prog_meta_q <= p_programm_i;
            prog_s      <= prog_meta_q;
            prog_prev_q <= prog_s;
            rx_meta_q   <= rx_i;
            rx_s        <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            maddr_q     <= maddr_d;
            mdata_q     <= mdata_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign receiving = (state_q == StWaitStart) || (state_q == StStart) ||
                       (state_q == StData) || (state_q == StStop);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        maddr_d = maddr_q;
        mdata_d = mdata_q;
        hold_d  = hold_q;
        done_d  = done_q;
        error_d = error_q;

        // Programming mode dropped before the image was complete.
        if (receiving && !prog_s) begin
            error_d = 1'b1;
            hold_d  = 1'b0;
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    hold_d = 1'b0;
                    if (prog_s && !prog_prev_q) begin
                        done_d  = 1'b0;
                        error_d = 1'b0;
                        addr_d  = '0;
                        hold_d  = 1'b1;
                        state_d = StWaitStart;
                    end
                end
                StWaitStart: begin
                    if (!rx_s) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = StStart;
                    end
                end
                StStart: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_d   = '0;
                        state_d = rx_s ? StWaitStart : StData;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StData: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = StStop;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StStop: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d = '0;
                        // Bits above the instruction word must be zero.
                        if (rx_s && ((shift_q >> WORD_W) == 8'd0)) begin
                            we_d    = 1'b1;
                            maddr_d = addr_q;
                            mdata_d = shift_q[WORD_W-1:0];
                            state_d = StWrite;
                        end else begin
                            error_d = 1'b1;
                            state_d = StAbort;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StWrite: begin
                    if (!prog_s) begin
                        error_d = 1'b1;
                        hold_d  = 1'b0;
                        state_d = StIdle;
                    end else if (addr_q == ADDR_LAST) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        state_d = StWaitStart;
                    end
                end
                StDone, StAbort: begin
                    if (!prog_s) begin
                        hold_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign mem_we_o   = we_q;
    assign mem_addr_o = maddr_q;
    assign mem_data_o = mdata_q;
    assign cpu_hold_o = hold_q;
    assign done_o     = done_q;
    assign error_o    = error_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: UART bytes in, expected memory writes scoreboarded by a
// monitor that compares each mem_we_o pulse against the queue.
module tb_program_loader;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       p_programm;
    logic       rx;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [6:0] mem_data;
    logic       cpu_hold;
    logic       done;
    logic       error;

    int         n_cmp = 0;
    int         n_err = 0;
    int         n_wr  = 0;
    logic       we_prev = 1'b0;
    logic [10:0] exp_q[$];

    program_loader #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .p_programm_i(p_programm),
        .rx_i        (rx),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_data),
        .cpu_hold_o  (cpu_hold),
        .done_o      (done),
        .error_o     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(CPB);
        end
        rx = stop_bit;
        cycles(CPB);
        rx = 1'b1;
        cycles(2 * CPB);
    endtask

    // Scoreboard monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we) begin
            check("we_single_cycle", {31'd0, we_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", {21'd0, mem_addr, mem_data}, 32'hFFFF_FFFF);
            end else begin
                check("write_addr_data", {21'd0, mem_addr, mem_data}, {21'd0, exp_q.pop_front()});
            end
            n_wr++;
        end
        we_prev <= mem_we;
    end

    initial begin
        logic [6:0] w;
        reset = 1'b1;
        p_programm = 1'b0;
        rx = 1'b1;
        cycles(3);
        check("reset_outputs", {21'd0, mem_we, mem_addr, mem_data, cpu_hold, done, error}, 32'd0);
        reset = 1'b0;
        cycles(4);
        check("idle_hold", {31'd0, cpu_hold}, 32'd0);

        // Full image load.
        p_programm = 1'b1;
        cycles(3);
        check("hold_after_entry", {29'd0, cpu_hold, done, error}, 32'b100);
        for (int k = 0; k < 16; k++) begin
            w = 7'((k * 9 + 3) & 32'h7F);
            exp_q.push_back({4'(k), w});
            send_byte({1'b0, w}, 1'b1);
            if (k == 14) check("not_done_early", {31'd0, done}, 32'd0);
        end
        check("done_after_16", {30'd0, done, cpu_hold}, 32'b11);
        check("writes_16", n_wr, 16);
        send_byte(8'h55, 1'b1);
        check("byte17_ignored", n_wr, 16);
        p_programm = 1'b0;
        cycles(4);
        check("release_after_done", {29'd0, cpu_hold, done, error}, 32'b010);

        // Nonzero upper bit aborts the load.
        p_programm = 1'b1;
        cycles(4);
        check("reentry_clears", {29'd0, cpu_hold, done, error}, 32'b100);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({4'(k), 7'(k + 16)});
            send_byte(8'(k + 16), 1'b1);
        end
        send_byte(8'h85, 1'b1);
        check("upper_bit_abort", {30'd0, cpu_hold, error}, 32'b11);
        check("writes_after_abort", n_wr, 19);
        send_byte(8'h01, 1'b1);
        check("abort_no_more_writes", n_wr, 19);
        p_programm = 1'b0;
        cycles(4);
        check("abort_release", {30'd0, cpu_hold, error}, 32'b01);

        // Framing error.
        p_programm = 1'b1;
        cycles(4);
        check("error_cleared", {31'd0, error}, 32'd0);
        send_byte(8'h12, 1'b0);
        check("framing_error", {30'd0, cpu_hold, error}, 32'b11);
        check("framing_no_write", n_wr, 19);
        p_programm = 1'b0;
        cycles(4);

        // Start-bit glitch, then valid bytes, then early exit.
        p_programm = 1'b1;
        cycles(4);
        rx = 1'b0;
        cycles(1);
        rx = 1'b1;
        cycles(3 * CPB);
        check("glitch_no_error", {30'd0, cpu_hold, error}, 32'b10);
        check("glitch_no_write", n_wr, 19);
        exp_q.push_back({4'd0, 7'h2A});
        send_byte(8'h2A, 1'b1);
        for (int k = 1; k < 5; k++) begin
            exp_q.push_back({4'(k), 7'(k * 5)});
            send_byte(8'(k * 5), 1'b1);
        end
        check("five_writes", n_wr, 24);
        p_programm = 1'b0;
        cycles(4);
        check("early_exit", {30'd0, cpu_hold, error}, 32'b01);

        // Restart from address 0, then reset mid-byte.
        p_programm = 1'b1;
        cycles(4);
        check("restart_clears_error", {31'd0, error}, 32'd0);
        exp_q.push_back({4'd0, 7'h11});
        send_byte(8'h11, 1'b1);
        check("restart_addr0", n_wr, 25);
        rx = 1'b0;
        cycles(CPB);
        rx = 1'b1;
        cycles(CPB);
        reset = 1'b1;
        p_programm = 1'b0;
        cycles(1);
        check("reset_mid_byte", {21'd0, mem_we, mem_addr, mem_data, cpu_hold, done, error}, 32'd0);
        reset = 1'b0;
        cycles(12 * CPB);
        check("no_write_after_reset", n_wr, 25);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
